// File: rtl/syzygy_adc_align_ctrl.sv
// Frame-word alignment for the SYZYGY ADC deserializer. It sweeps the IDELAY taps and bitslips
// until frame_q holds FRAME_PATTERN for LOCK_COUNT cycles, then keeps watch over the lock.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD_TAP | dly_load pulse with dly_cntvalue applied to the IDELAYs
// SETTLE   | wait SETTLE_CYCLES after a tap load or bitslip, frame_q ignored
// CHECK    | compare frame_q, count down the remaining consecutive matches
// SLIP     | bitslip pulse, advance slip_count
// LOCKED   | aligned, count down the tolerated consecutive mismatches
// FAIL     | every tap and slip combination exhausted
module syzygy_adc_align_ctrl #(
  parameter logic [7:0] FRAME_PATTERN = 8'hF0,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         LOCK_COUNT    = 16,
  parameter logic [8:0] TAP_STEP      = 9'd32,
  parameter logic [8:0] TAP_MAX       = 9'd480,
  parameter int         LOSS_COUNT    = 3
) (
  input  logic       slow_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] frame_q,
  output logic       bitslip,
  output logic       dly_load,
  output logic [8:0] dly_cntvalue,
  output logic [2:0] slip_count,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic       lock_lost
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int LW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_LOAD  = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] MISS_LOAD   = LW'(LOSS_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TAP,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;

  logic       frame_ok;
  logic [9:0] next_tap;
  logic       tap_room;

  assign frame_ok = (frame_q == FRAME_PATTERN);
  // one extra bit so a step past TAP_MAX is caught instead of wrapping to a low tap
  assign next_tap = {1'b0, dly_cntvalue} + {1'b0, TAP_STEP};
  assign tap_room = (next_tap <= {1'b0, TAP_MAX});

  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dly_cntvalue <= '0;
      slip_count   <= '0;
      settle_cnt   <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      bitslip      <= 1'b0;
      dly_load     <= 1'b0;
      busy         <= 1'b0;
      locked       <= 1'b0;
      fail         <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      bitslip   <= 1'b0;
      dly_load  <= 1'b0;
      lock_lost <= 1'b0;

      case (state)
        IDLE, FAIL: begin
          if (start) begin
            dly_cntvalue <= '0;
            slip_count   <= '0;
            dly_load     <= 1'b1;
            busy         <= 1'b1;
            locked       <= 1'b0;
            fail         <= 1'b0;
            state        <= LOAD_TAP;
          end
        end

        LOAD_TAP: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end

        SETTLE: begin
          match_cnt <= MATCH_LOAD;
          if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end

        CHECK: begin
          if (frame_ok) begin
            if (match_cnt == '0) begin
              locked   <= 1'b1;
              busy     <= 1'b0;
              miss_cnt <= MISS_LOAD;
              state    <= LOCKED;
            end else begin
              match_cnt <= match_cnt - MW'(1);
            end
          end else if (slip_count != 3'd7) begin
            bitslip <= 1'b1;
            state   <= SLIP;
          end else if (tap_room) begin
            dly_cntvalue <= next_tap[8:0];
            slip_count   <= '0;
            dly_load     <= 1'b1;
            state        <= LOAD_TAP;
          end else begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= FAIL;
          end
        end

        SLIP: begin
          slip_count <= slip_count + 3'd1;
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end

        LOCKED: begin
          // a restart request wins over a coincident loss of lock
          if (start) begin
            dly_cntvalue <= '0;
            slip_count   <= '0;
            dly_load     <= 1'b1;
            busy         <= 1'b1;
            locked       <= 1'b0;
            state        <= LOAD_TAP;
          end else if (frame_ok) begin
            miss_cnt <= MISS_LOAD;
          end else if (miss_cnt == '0) begin
            lock_lost    <= 1'b1;
            dly_cntvalue <= '0;
            slip_count   <= '0;
            dly_load     <= 1'b1;
            busy         <= 1'b1;
            locked       <= 1'b0;
            state        <= LOAD_TAP;
          end else begin
            miss_cnt <= miss_cnt - LW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
